debug_bridge: RTL and testbench

- Parametrised IO-bus slave for the monitor discus core. It gives the monitor access to a target core's program and data memories.
- It also handles a bit-banged UART pin, a bank of LEDs, target reset/hold control and a cycle-counted single-step run.
- It sits between the monitor core's memory port and the port-B side of the target's dual-port program/data RAMs, which live outside the block.
- New over the previous generation: configurable memory depths beyond 256 (two-byte address registers), optional address auto-increment, LED count/polarity parameters, and a hold/step engine.

---
 rtl/debug_bridge_pkg.sv | 20 ++
 rtl/debug_bridge_mem_port.sv | 47 ++++
 rtl/debug_bridge.sv | 136 +++++++++++++
 tb/tb_debug_bridge.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_bridge_pkg.sv
// rtl/debug_bridge_pkg.sv - register map and control bit positions for the debug bridge
package debug_bridge_pkg;

    localparam logic [3:0] REG_PADR_LO = 4'd0;
    localparam logic [3:0] REG_PADR_HI = 4'd1;
    localparam logic [3:0] REG_PDATA   = 4'd2;
    localparam logic [3:0] REG_DADR_LO = 4'd3;
    localparam logic [3:0] REG_DADR_HI = 4'd4;
    localparam logic [3:0] REG_DDATA   = 4'd5;
    localparam logic [3:0] REG_UART    = 4'd6;
    localparam logic [3:0] REG_LED     = 4'd7;
    localparam logic [3:0] REG_CTRL    = 4'd8;
    localparam logic [3:0] REG_STEP    = 4'd9;
    localparam logic [3:0] REG_STATUS  = 4'd10;

    localparam int CTRL_RESET_BIT   = 0;
    localparam int CTRL_AUTOINC_BIT = 1;
    localparam int CTRL_HOLD_BIT    = 2;

endpackage

// File: rtl/debug_bridge_mem_port.sv
// rtl/debug_bridge_mem_port.sv - memory address register with byte loads, auto-increment and write strobe
module mem_port_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          lo_we,
    input  logic          hi_we,
    input  logic          data_we,
    input  logic          inc,
    input  logic [7:0]    wdata,
    output logic [AW-1:0] addr,
    output logic [7:0]    addr_lo,
    output logic [7:0]    addr_hi,
    output logic [7:0]    mem_wdata,
    output logic          mem_we
);

    logic [15:0] addr_ext;
    logic [15:0] addr_load;
    logic        unused_load;

    // Byte loads work on a 16-bit view so that bits beyond AW simply fall away.
    always_comb begin
        addr_ext  = 16'(addr);
        addr_load = addr_ext;
        if (lo_we) addr_load[7:0]  = wdata;
        if (hi_we) addr_load[15:8] = wdata;
    end

    assign unused_load = ^addr_load;
    assign addr_lo     = addr_ext[7:0];
    assign addr_hi     = addr_ext[15:8];
    assign mem_wdata   = wdata;
    assign mem_we      = data_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (lo_we || hi_we) begin
            addr <= addr_load[AW-1:0];
        end else if (inc) begin
            addr <= addr + AW'(1);
        end
    end

endmodule

// File: rtl/debug_bridge.sv
// rtl/debug_bridge.sv - monitor IO slave giving access to target RAMs, UART pin, LEDs and run control
module debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int         PROG_AW    = 8,
    parameter int         DATA_AW    = 8,
    parameter int         NUM_LEDS   = 4,
    parameter logic [7:0] LED_INVERT = 8'h02,
    parameter int         STEP_W     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                io_read,
    input  logic                io_write,
    input  logic [7:0]          io_address,
    input  logic [7:0]          io_D,
    output logic [7:0]          io_Q,
    output logic [PROG_AW-1:0]  prog_addr,
    output logic [7:0]          prog_wdata,
    output logic                prog_we,
    input  logic [7:0]          prog_rdata,
    output logic [DATA_AW-1:0]  data_addr,
    output logic [7:0]          data_wdata,
    output logic                data_we,
    input  logic [7:0]          data_rdata,
    input  logic                uart_rxd,
    output logic                uart_txd,
    output logic [NUM_LEDS-1:0] led,
    output logic                target_reset,
    output logic                target_run
);

    logic [3:0]          reg_sel;
    logic                unused_addr_hi;
    logic                autoinc;
    logic                hold;
    logic [STEP_W-1:0]   step_cnt;
    logic                stepping;
    logic [NUM_LEDS-1:0] led_reg;
    logic                rx_meta;
    logic                rx_sync;
    logic [7:0]          padr_lo, padr_hi, dadr_lo, dadr_hi;
    logic [7:0]          rd_mux;

    assign reg_sel        = io_address[3:0];
    assign unused_addr_hi = ^io_address[7:4];
    assign stepping       = (step_cnt != '0);
    assign target_run     = !hold || stepping;
    assign led            = led_reg ^ LED_INVERT[NUM_LEDS-1:0];

    // A simultaneous read and write of a DATA register share one increment.
    mem_port_ctrl #(.AW(PROG_AW)) u_prog_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .lo_we     (io_write && reg_sel == REG_PADR_LO),
        .hi_we     (io_write && reg_sel == REG_PADR_HI),
        .data_we   (io_write && reg_sel == REG_PDATA),
        .inc       (autoinc && reg_sel == REG_PDATA && (io_read || io_write)),
        .wdata     (io_D),
        .addr      (prog_addr),
        .addr_lo   (padr_lo),
        .addr_hi   (padr_hi),
        .mem_wdata (prog_wdata),
        .mem_we    (prog_we)
    );

    mem_port_ctrl #(.AW(DATA_AW)) u_data_port (
        .clk       (clk),
        .reset_n   (reset_n),
        .lo_we     (io_write && reg_sel == REG_DADR_LO),
        .hi_we     (io_write && reg_sel == REG_DADR_HI),
        .data_we   (io_write && reg_sel == REG_DDATA),
        .inc       (autoinc && reg_sel == REG_DDATA && (io_read || io_write)),
        .wdata     (io_D),
        .addr      (data_addr),
        .addr_lo   (dadr_lo),
        .addr_hi   (dadr_hi),
        .mem_wdata (data_wdata),
        .mem_we    (data_we)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            uart_txd     <= 1'b1;
            led_reg      <= '0;
            target_reset <= 1'b1;
            autoinc      <= 1'b0;
            hold         <= 1'b0;
            step_cnt     <= '0;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
            if (io_write && reg_sel == REG_UART) uart_txd <= io_D[0];
            if (io_write && reg_sel == REG_LED)  led_reg  <= io_D[NUM_LEDS-1:0];
            if (io_write && reg_sel == REG_CTRL) begin
                target_reset <= io_D[CTRL_RESET_BIT];
                autoinc      <= io_D[CTRL_AUTOINC_BIT];
                hold         <= io_D[CTRL_HOLD_BIT];
            end
            if (io_write && reg_sel == REG_STEP) begin
                step_cnt <= io_D[STEP_W-1:0];
            end else if (stepping) begin
                step_cnt <= step_cnt - STEP_W'(1);
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            REG_PADR_LO: rd_mux = padr_lo;
            REG_PADR_HI: rd_mux = padr_hi;
            REG_PDATA:   rd_mux = prog_rdata;
            REG_DADR_LO: rd_mux = dadr_lo;
            REG_DADR_HI: rd_mux = dadr_hi;
            REG_DDATA:   rd_mux = data_rdata;
            REG_UART:    rd_mux = {7'b0, rx_sync};
            REG_LED:     rd_mux = 8'(led_reg);
            REG_CTRL:    rd_mux = {5'b0, hold, autoinc, target_reset};
            REG_STEP:    rd_mux = 8'(step_cnt);
            REG_STATUS:  rd_mux = {6'b0, rx_sync, stepping};
            default:     rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_Q <= 8'h00;
        end else begin
            io_Q <= io_read ? rd_mux : 8'h00;
        end
    end

endmodule

// File: tb/tb_debug_bridge.sv
// tb/tb_debug_bridge.sv - self-checking bench for debug_bridge with RAM models and a reference model
module tb_debug_bridge;
    import debug_bridge_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       io_read, io_write;
    logic [7:0] io_address, io_D, io_Q;
    logic [9:0] prog_addr;
    logic [7:0] prog_wdata, prog_rdata;
    logic       prog_we;
    logic [7:0] data_addr;
    logic [7:0] data_wdata, data_rdata;
    logic       data_we;
    logic       uart_rxd, uart_txd;
    logic [3:0] led;
    logic       target_reset, target_run;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog_mem [0:1023];
    logic [7:0] data_mem [0:255];

    always #5 clk = ~clk;

    debug_bridge #(
        .PROG_AW(10), .DATA_AW(8), .NUM_LEDS(4), .LED_INVERT(8'h02), .STEP_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .io_read(io_read), .io_write(io_write),
        .io_address(io_address), .io_D(io_D), .io_Q(io_Q),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_we(prog_we), .prog_rdata(prog_rdata),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_rdata(data_rdata),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .led(led),
        .target_reset(target_reset), .target_run(target_run)
    );

    always @(posedge clk) begin
        if (prog_we) prog_mem[prog_addr] <= prog_wdata;
        prog_rdata <= prog_mem[prog_addr];
        if (data_we) data_mem[data_addr] <= data_wdata;
        data_rdata <= data_mem[data_addr];
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        io_address = {4'h0, a};
        io_D       = d;
        io_write   = 1'b1;
        @(negedge clk);
        io_write   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] q);
        io_address = {4'h0, a};
        io_read    = 1'b1;
        @(negedge clk);
        io_read    = 1'b0;
        q          = io_Q;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; io_read = 1'b0; io_write = 1'b0;
        io_address = 8'h00; io_D = 8'h00; uart_rxd = 1'b1;
        #12;
        n_checks++; if (uart_txd !== 1'b1) $display("FAIL rst_txd got %b want 1", uart_txd); else n_pass++;
        n_checks++; if (target_reset !== 1'b1) $display("FAIL rst_target_reset got %b want 1", target_reset); else n_pass++;
        n_checks++; if (target_run !== 1'b1) $display("FAIL rst_target_run got %b want 1", target_run); else n_pass++;
        n_checks++; if (led !== 4'b0010) $display("FAIL rst_led got %b want 0010", led); else n_pass++;
        n_checks++; if (io_Q !== 8'h00) $display("FAIL rst_io_q got %h want 00", io_Q); else n_pass++;
        n_checks++; if (prog_we !== 1'b0 || data_we !== 1'b0) $display("FAIL rst_we got %b%b want 00", prog_we, data_we); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prog_wrap;
        logic [7:0] q;
        wr(REG_CTRL, 8'h02);
        wr(REG_PADR_LO, 8'hFE);
        wr(REG_PADR_HI, 8'h03);
        wr(REG_PDATA, 8'd11);
        wr(REG_PDATA, 8'd22);
        wr(REG_PDATA, 8'd33);
        n_checks++; if (prog_mem[10'h3FE] !== 8'd11) $display("FAIL wrap_mem3fe got %0d want 11", prog_mem[10'h3FE]); else n_pass++;
        n_checks++; if (prog_mem[10'h3FF] !== 8'd22) $display("FAIL wrap_mem3ff got %0d want 22", prog_mem[10'h3FF]); else n_pass++;
        n_checks++; if (prog_mem[10'h000] !== 8'd33) $display("FAIL wrap_mem000 got %0d want 33", prog_mem[10'h000]); else n_pass++;
        n_checks++; if (prog_addr !== 10'd1) $display("FAIL wrap_addr got %h want 001", prog_addr); else n_pass++;
        rd(REG_PADR_LO, q);
        n_checks++; if (q !== 8'h01) $display("FAIL wrap_padr_lo got %h want 01", q); else n_pass++;
        rd(REG_PADR_HI, q);
        n_checks++; if (q !== 8'h00) $display("FAIL wrap_padr_hi got %h want 00", q); else n_pass++;
    endtask

    task automatic test_data_read;
        logic [7:0] q;
        wr(REG_CTRL, 8'h00);
        wr(REG_DADR_LO, 8'h05);
        wr(REG_DDATA, 8'hA5);
        idle(2);
        rd(REG_DDATA, q);
        n_checks++; if (q !== 8'hA5) $display("FAIL ddata_read got %h want a5", q); else n_pass++;
        @(negedge clk);
        n_checks++; if (io_Q !== 8'h00) $display("FAIL ddata_idle_q got %h want 00", io_Q); else n_pass++;
        wr(REG_DADR_HI, 8'hFF);
        n_checks++; if (data_addr !== 8'h05) $display("FAIL dadr_hi_ignored got %h want 05", data_addr); else n_pass++;
        rd(REG_DADR_HI, q);
        n_checks++; if (q !== 8'h00) $display("FAIL dadr_hi_read got %h want 00", q); else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [7:0] q;
        wr(REG_CTRL, 8'h00);
        wr(REG_PADR_LO, 8'h10);
        wr(REG_PADR_HI, 8'h00);
        wr(REG_PDATA, 8'h77);
        wr(REG_CTRL, 8'h02);
        idle(2);
        io_address = {4'h0, REG_PDATA}; io_D = 8'h88;
        io_read = 1'b1; io_write = 1'b1;
        @(negedge clk);
        io_read = 1'b0; io_write = 1'b0;
        q = io_Q;
        n_checks++; if (q !== 8'h77) $display("FAIL rw_prewrite got %h want 77", q); else n_pass++;
        n_checks++; if (prog_addr !== 10'h011) $display("FAIL rw_single_inc got %h want 011", prog_addr); else n_pass++;
        n_checks++; if (prog_mem[10'h010] !== 8'h88) $display("FAIL rw_mem got %h want 88", prog_mem[10'h010]); else n_pass++;
        rd(REG_CTRL, q);
        n_checks++; if (q !== 8'h02) $display("FAIL ctrl_read got %h want 02", q); else n_pass++;
    endtask

    task automatic test_random_mem;
        logic [7:0] mref [0:1023];
        bit         valid [0:1023];
        int         a, ai;
        logic [7:0] d, q, lo;
        for (int k = 0; k < 1024; k++) valid[k] = 1'b0;
        ai = 0;
        wr(REG_CTRL, 8'h00);
        wr(REG_PADR_LO, 8'h00);
        wr(REG_PADR_HI, 8'h00);
        a = 0;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    lo = 8'($urandom_range(0, 7));
                    d  = 8'($urandom_range(0, 255));
                    wr(REG_PADR_LO, lo);
                    wr(REG_PADR_HI, d);
                    a = (int'(d) % 4) * 256 + int'(lo);
                end
                1: begin
                    d = 8'($urandom_range(0, 255));
                    wr(REG_PDATA, d);
                    mref[a] = d; valid[a] = 1'b1;
                    if (ai != 0) a = (a + 1) % 1024;
                end
                2: begin
                    if (valid[a]) begin
                        idle(2);
                        rd(REG_PDATA, q);
                        n_checks++; if (q !== mref[a]) $display("FAIL rnd_read @%h got %h want %h", a, q, mref[a]); else n_pass++;
                        if (ai != 0) a = (a + 1) % 1024;
                    end
                end
                default: begin
                    ai = int'($urandom_range(0, 1));
                    wr(REG_CTRL, (ai != 0) ? 8'h02 : 8'h00);
                end
            endcase
            n_checks++; if (prog_addr !== 10'(a)) $display("FAIL rnd_addr got %h want %h", prog_addr, 10'(a)); else n_pass++;
        end
    endtask

    task automatic test_led;
        logic [7:0] d, q;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            wr(REG_LED, d);
            n_checks++; if (led !== (d[3:0] ^ 4'b0010)) $display("FAIL led_pins got %b want %b", led, d[3:0] ^ 4'b0010); else n_pass++;
            rd(REG_LED, q);
            n_checks++; if (q !== {4'h0, d[3:0]}) $display("FAIL led_read got %h want %h", q, {4'h0, d[3:0]}); else n_pass++;
        end
    endtask

    task automatic test_unmapped;
        logic [7:0] q;
        for (int r = 11; r < 16; r++) begin
            wr(4'(r), 8'hFF);
            rd(4'(r), q);
            n_checks++; if (q !== 8'h00) $display("FAIL unmapped_%0d got %h want 00", r, q); else n_pass++;
        end
        rd(REG_CTRL, q);
        n_checks++; if (q !== 8'h02 && q !== 8'h00) $display("FAIL unmapped_ctrl got %h want 00/02", q); else n_pass++;
    endtask

    task automatic test_uart;
        logic [7:0] q;
        uart_rxd = 1'b0;
        rd(REG_UART, q);
        n_checks++; if (q !== 8'h01) $display("FAIL uart_sync_delay got %h want 01", q); else n_pass++;
        idle(2);
        rd(REG_UART, q);
        n_checks++; if (q !== 8'h00) $display("FAIL uart_rx_low got %h want 00", q); else n_pass++;
        rd(REG_STATUS, q);
        n_checks++; if (q !== 8'h00) $display("FAIL status_rx_low got %h want 00", q); else n_pass++;
        uart_rxd = 1'b1;
        idle(3);
        rd(REG_STATUS, q);
        n_checks++; if (q !== 8'h02) $display("FAIL status_rx_high got %h want 02", q); else n_pass++;
        wr(REG_UART, 8'hFE);
        n_checks++; if (uart_txd !== 1'b0) $display("FAIL uart_txd0 got %b want 0", uart_txd); else n_pass++;
        wr(REG_UART, 8'h01);
        n_checks++; if (uart_txd !== 1'b1) $display("FAIL uart_txd1 got %b want 1", uart_txd); else n_pass++;
    endtask

    task automatic test_step;
        logic [7:0] q;
        int         high;
        wr(REG_CTRL, 8'h04);
        n_checks++; if (target_run !== 1'b0 || target_reset !== 1'b0) $display("FAIL hold_idle got run=%b rst=%b want 0 0", target_run, target_reset); else n_pass++;
        wr(REG_STEP, 8'd3);
        high = 0;
        for (int i = 0; i < 8; i++) begin
            if (target_run === 1'b1) high++;
            @(negedge clk);
        end
        n_checks++; if (high != 3) $display("FAIL step3_cycles got %0d want 3", high); else n_pass++;
        wr(REG_STEP, 8'd3);
        rd(REG_STEP, q);
        n_checks++; if (q !== 8'd3) $display("FAIL step_read got %0d want 3", q); else n_pass++;
        idle(1);
        wr(REG_STEP, 8'd5);
        high = 0;
        for (int i = 0; i < 10; i++) begin
            if (target_run === 1'b1) high++;
            @(negedge clk);
        end
        n_checks++; if (high != 5) $display("FAIL step_reload got %0d want 5", high); else n_pass++;
        wr(REG_STEP, 8'd9);
        wr(REG_STEP, 8'd0);
        n_checks++; if (target_run !== 1'b0) $display("FAIL step_abort got %b want 0", target_run); else n_pass++;
        rd(REG_STATUS, q);
        n_checks++; if (q !== 8'h02) $display("FAIL status_idle got %h want 02", q); else n_pass++;
    endtask

    task automatic test_async_reset;
        logic [7:0] q;
        wr(REG_CTRL, 8'h04);
        wr(REG_STEP, 8'd50);
        idle(3);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (target_run !== 1'b1) $display("FAIL areset_run got %b want 1", target_run); else n_pass++;
        n_checks++; if (target_reset !== 1'b1) $display("FAIL areset_target_reset got %b want 1", target_reset); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        rd(REG_STEP, q);
        n_checks++; if (q !== 8'd0) $display("FAIL areset_step got %0d want 0", q); else n_pass++;
        rd(REG_CTRL, q);
        n_checks++; if (q !== 8'h01) $display("FAIL areset_ctrl got %h want 01", q); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_prog_wrap();
        test_data_read();
        test_simultaneous();
        test_random_mem();
        test_led();
        test_unmapped();
        test_uart();
        test_step();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
